// File: rtl/div3_serial_if.sv
// Handshake bundle for the serial divide-by-3 unit.
// Signals:
//   in_valid/in_ready/in_data       operand side (producer -> divider)
//   out_valid/out_ready             result side (divider -> consumer)
//   quotient/remainder              result payload
// Modports: slave = divider, master = the agent that drives operands and consumes results.
interface div3_serial_if #(
    parameter int unsigned DATA_LEN = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] quotient;
    logic [1:0]          remainder;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder
    );
endinterface

// File: rtl/div3_serial.sv
// Sequential divide-by-3: MSB-first long division of an unsigned DATA_LEN-bit
// operand, producing the full quotient and a 2-bit remainder (0..2).
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    div3_serial_if.slave: in_valid/in_ready/in_data, out_valid/out_ready,
//          quotient/remainder (all outputs registered)
// Build option: define DIV3_FAST_EN to retire 2 operand bits per cycle
// (DATA_LEN must then be even); results are identical in both builds.
module div3_serial #(
    parameter int unsigned DATA_LEN = 8,
    parameter int unsigned CNT_LEN  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    div3_serial_if.slave  bus
);

`ifdef DIV3_FAST_EN
    localparam int unsigned BITS_PER_STEP = 2;
`else
    localparam int unsigned BITS_PER_STEP = 1;
`endif
    localparam logic [CNT_LEN-1:0] CNT_INIT = CNT_LEN'(DATA_LEN / BITS_PER_STEP - 1);

    // Elaboration-time parameter sanity
    if (DATA_LEN < 2) begin : g_len_chk
        $error("div3_serial: DATA_LEN must be >= 2");
    end
    if ((2 ** CNT_LEN) <= DATA_LEN) begin : g_cnt_chk
        $error("div3_serial: CNT_LEN too small for DATA_LEN");
    end
`ifdef DIV3_FAST_EN
    if ((DATA_LEN % 2) != 0) begin : g_even_chk
        $error("div3_serial: DATA_LEN must be even with DIV3_FAST_EN");
    end
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_LEN-1:0] shift_q, shift_d;
    logic [DATA_LEN-1:0] acc_q, acc_d;
    logic [1:0]          rem_q, rem_d;
    logic [CNT_LEN-1:0]  cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_LEN-1:0] quot_q, quot_d;
    logic [1:0]          rem_out_q, rem_out_d;

    logic [DATA_LEN-1:0] shift_step;
    logic [DATA_LEN-1:0] acc_step;
    logic [1:0]          rem_step;

    // One remainder-recurrence step: t = 2*rem + b; returns {qbit, rem_next}
    function automatic logic [2:0] div3_step(input logic [1:0] rem, input logic b);
        logic [2:0] t;
        t = {rem, b};
        if (t >= 3'd3) begin
            return {1'b1, 2'(t - 3'd3)};
        end
        return {1'b0, t[1:0]};
    endfunction

`ifdef DIV3_FAST_EN
    logic [2:0] step_hi;
    logic [2:0] step_lo;

    // Two chained recurrence steps per cycle
    always_comb begin
        step_hi    = div3_step(rem_q, shift_q[DATA_LEN-1]);
        step_lo    = div3_step(step_hi[1:0], shift_q[DATA_LEN-2]);
        acc_step   = (acc_q << 2) | DATA_LEN'({step_hi[2], step_lo[2]});
        rem_step   = step_lo[1:0];
        shift_step = shift_q << 2;
    end
`else
    logic [2:0] step_one;

    // Single recurrence step per cycle
    always_comb begin
        step_one   = div3_step(rem_q, shift_q[DATA_LEN-1]);
        acc_step   = (acc_q << 1) | DATA_LEN'(step_one[2]);
        rem_step   = step_one[1:0];
        shift_step = shift_q << 1;
    end
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quot_q      <= quot_d;
            rem_out_q   <= rem_out_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        quot_d      = quot_q;
        rem_out_d   = rem_out_q;

        case (state_q)
            IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (bus.in_valid && in_ready_q) begin
                    shift_d    = bus.in_data;
                    acc_d      = '0;
                    rem_d      = '0;
                    cnt_d      = CNT_INIT;
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                in_ready_d = 1'b0;
                shift_d    = shift_step;
                acc_d      = acc_step;
                rem_d      = rem_step;
                if (cnt_q == '0) begin
                    // Publish the result on the same edge the last bits retire
                    quot_d      = acc_step;
                    rem_out_d   = rem_step;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_LEN'(1);
                end
            end
            DONE: begin
                in_ready_d = 1'b0;
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_out_q;

endmodule
